// File: rtl/blinds_ctrl.sv
// Roller-blind motor sequencer: manual/auto arbitration, limits, dead time, travel timeout.
// Optional position counter output enabled by defining BLINDS_POSITION_EN.
module blinds_ctrl #(
    parameter int unsigned TRAVEL_MAX = 200,
    parameter int unsigned DEAD_TIME  = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             auto_req,
    input  logic             auto_dir,
    output logic             auto_ack,
    input  logic             lim_top,
    input  logic             lim_bottom,
    input  logic             fault_clr,
`ifdef BLINDS_POSITION_EN
    output logic [CNT_W-1:0] pos,
`endif
    output logic             motor_up,
    output logic             motor_down,
    output logic             busy,
    output logic             fault
);

    typedef enum logic [2:0] {StIdle, StUp, StDown, StDead, StFault} state_e;

    localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] DeadLast   = CNT_W'(DEAD_TIME - 1);

    state_e           state_q;
    logic             src_q;
    logic [CNT_W-1:0] travel_q;
    logic [CNT_W-1:0] dead_q;

    logic btn_any, man_up, man_dn, auto_ok, lim_bad;
    logic eval_idle, go_up, go_dn, go_src, go_ack;
    logic up_exit, dn_exit;

    always_comb begin
        btn_any = btn_up | btn_down;
        man_up  = btn_up & ~btn_down;
        man_dn  = btn_down & ~btn_up;
        lim_bad = lim_top & lim_bottom;
        // An ack still visible means the requester has not yet seen it; don't re-accept.
        auto_ok = auto_req & ~btn_any & ~auto_ack;

        eval_idle = (state_q == StIdle) || (state_q == StDead && dead_q == DeadLast);

        go_up  = 1'b0;
        go_dn  = 1'b0;
        go_src = 1'b0;
        go_ack = 1'b0;
        if (man_up) begin
            go_up = ~lim_top;
        end else if (man_dn) begin
            go_dn = ~lim_bottom;
        end else if (auto_ok) begin
            go_ack = 1'b1;
            go_src = 1'b1;
            go_up  = auto_dir & ~lim_top;
            go_dn  = ~auto_dir & ~lim_bottom;
        end

        up_exit = lim_top    | (src_q ? btn_any : (~btn_up | btn_down));
        dn_exit = lim_bottom | (src_q ? btn_any : (~btn_down | btn_up));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            src_q      <= 1'b0;
            travel_q   <= '0;
            dead_q     <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            auto_ack   <= 1'b0;
        end else begin
            auto_ack <= 1'b0;
            if (lim_bad) begin
                state_q    <= StFault;
                motor_up   <= 1'b0;
                motor_down <= 1'b0;
                busy       <= 1'b0;
                fault      <= 1'b1;
            end else if (eval_idle) begin
                auto_ack   <= go_ack;
                motor_up   <= go_up;
                motor_down <= go_dn;
                busy       <= go_up | go_dn;
                travel_q   <= '0;
                if (go_up || go_dn) src_q <= go_src;
                state_q <= go_up ? StUp : (go_dn ? StDown : StIdle);
            end else begin
                unique case (state_q)
                    StUp, StDown: begin
                        if ((state_q == StUp) ? up_exit : dn_exit) begin
                            state_q    <= StDead;
                            dead_q     <= '0;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end else if (travel_q == TravelLast) begin
                            state_q    <= StFault;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                            busy       <= 1'b0;
                            fault      <= 1'b1;
                        end else begin
                            travel_q <= travel_q + 1'b1;
                        end
                    end
                    StDead: dead_q <= dead_q + 1'b1;
                    StFault: begin
                        if (fault_clr) begin
                            state_q <= StDead;
                            dead_q  <= '0;
                            fault   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef BLINDS_POSITION_EN
    always_ff @(posedge clk) begin
        if (rst || lim_bottom) begin
            pos <= '0;
        end else if (motor_up && pos != {CNT_W{1'b1}}) begin
            pos <= pos + 1'b1;
        end else if (motor_down && pos != '0) begin
            pos <= pos - 1'b1;
        end
    end
`endif

endmodule
